// File: rtl/trig_rom_arbiter.sv
// Two-requester round-robin front end for a shared sin/cos ROM.
// Tags ride alongside the ROM latency so each response returns to its owner.
module trig_rom_arbiter #(
    parameter int ANGLE_W = 9,
    parameter int DATA_W  = 11,
    parameter int ROM_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               p_req_valid,
    input  logic [ANGLE_W-1:0] p_req_angle,
    output logic               p_req_ready,
    input  logic               o_req_valid,
    input  logic [ANGLE_W-1:0] o_req_angle,
    output logic               o_req_ready,
    output logic               rom_en,
    output logic [ANGLE_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]  rom_cos,
    input  logic [DATA_W-1:0]  rom_sin,
    output logic               p_resp_valid,
    output logic               o_resp_valid,
    output logic [DATA_W-1:0]  p_cos,
    output logic [DATA_W-1:0]  p_sin,
    output logic [DATA_W-1:0]  o_cos,
    output logic [DATA_W-1:0]  o_sin,
    output logic               busy
);

    localparam logic [ANGLE_W-1:0] DEG_360 = ANGLE_W'(360);

    typedef enum logic {
        REQ_P = 1'b0,
        REQ_O = 1'b1
    } req_id_t;

    req_id_t            last_grant;
    logic               accept;
    req_id_t            sel_id;
    logic [ANGLE_W-1:0] sel_angle;
    logic [ANGLE_W-1:0] norm_angle;
    logic [ANGLE_W-1:0] addr_q;
    logic [ROM_LAT-1:0] tag_v;
    logic [ROM_LAT-1:0] tag_id;
    logic               head_v;
    logic               head_id;

    // Ready is gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        p_req_ready = rst_n & p_req_valid &
                      (~o_req_valid | (last_grant == REQ_O));
        o_req_ready = rst_n & o_req_valid &
                      (~p_req_valid | (last_grant == REQ_P));
        accept      = p_req_ready | o_req_ready;
        sel_id      = o_req_ready ? REQ_O : REQ_P;
        sel_angle   = o_req_ready ? o_req_angle : p_req_angle;
        if (sel_angle >= DEG_360) begin
            norm_angle = sel_angle - DEG_360;
        end else begin
            norm_angle = sel_angle;
        end
        rom_en   = accept;
        rom_addr = accept ? norm_angle : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_O;
            addr_q     <= '0;
        end else if (accept) begin
            last_grant <= sel_id;
            addr_q     <= norm_angle;
        end
    end

    // Tag pipe mirrors the ROM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= accept;
            tag_id[0] <= sel_id;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign head_v  = tag_v[ROM_LAT-1];
    assign head_id = tag_id[ROM_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_resp_valid <= 1'b0;
            o_resp_valid <= 1'b0;
            p_cos        <= '0;
            p_sin        <= '0;
            o_cos        <= '0;
            o_sin        <= '0;
        end else begin
            p_resp_valid <= 1'b0;
            o_resp_valid <= 1'b0;
            unique case (1'b1)
                head_v && !head_id: begin
                    p_resp_valid <= 1'b1;
                    p_cos        <= rom_cos;
                    p_sin        <= rom_sin;
                end
                head_v && head_id: begin
                    o_resp_valid <= 1'b1;
                    o_cos        <= rom_cos;
                    o_sin        <= rom_sin;
                end
                default: ;
            endcase
        end
    end

    assign busy = (|tag_v) | p_resp_valid | o_resp_valid;

endmodule

// File: tb/tb_trig_rom_arbiter.sv
// Scoreboard bench for trig_rom_arbiter with a latency-accurate ROM model.
module tb_trig_rom_arbiter;

    localparam int AW  = 9;
    localparam int DW  = 11;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p_req_valid, o_req_valid;
    logic [AW-1:0] p_req_angle, o_req_angle;
    logic          p_req_ready, o_req_ready;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_cos, rom_sin;
    logic          p_resp_valid, o_resp_valid;
    logic [DW-1:0] p_cos, p_sin, o_cos, o_sin;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int wait_p = 0;
    int wait_o = 0;

    typedef struct {
        logic          id;
        logic [DW-1:0] c;
        logic [DW-1:0] s;
        int            at;
    } exp_t;

    exp_t sb[$];

    trig_rom_arbiter #(
        .ANGLE_W(AW),
        .DATA_W (DW),
        .ROM_LAT(LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .p_req_valid (p_req_valid),
        .p_req_angle (p_req_angle),
        .p_req_ready (p_req_ready),
        .o_req_valid (o_req_valid),
        .o_req_angle (o_req_angle),
        .o_req_ready (o_req_ready),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_cos     (rom_cos),
        .rom_sin     (rom_sin),
        .p_resp_valid(p_resp_valid),
        .o_resp_valid(o_resp_valid),
        .p_cos       (p_cos),
        .p_sin       (p_sin),
        .o_cos       (o_cos),
        .o_sin       (o_sin),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] cos_of(input logic [AW-1:0] a);
        if (a == 9'd90) return '0;
        if (a == 9'd0) return DW'(1024);
        return DW'(a * 2 + 1);
    endfunction

    function automatic logic [DW-1:0] sin_of(input logic [AW-1:0] a);
        if (a == 9'd90) return DW'(1024);
        if (a == 9'd0) return '0;
        return DW'(a * 3 + 5);
    endfunction

    function automatic logic [AW-1:0] norm(input logic [AW-1:0] a);
        if (a >= 9'd360) return AW'(a - 9'd360);
        return a;
    endfunction

    // ROM: data for the address seen LAT edges ago.
    logic [AW-1:0] a_pipe [LAT];
    always @(posedge clk) begin
        a_pipe[0] <= rom_addr;
        for (int i = 1; i < LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign rom_cos = cos_of(a_pipe[LAT-1]);
    assign rom_sin = sin_of(a_pipe[LAT-1]);

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            sb.delete();
            wait_p = 0;
            wait_o = 0;
        end else begin
            checks++;
            if (p_req_ready && o_req_ready) begin
                errors++;
                $display("FAIL grant_excl cyc %0d: both ready", cyc);
            end
            checks++;
            if ((p_req_ready && !p_req_valid) || (o_req_ready && !o_req_valid)) begin
                errors++;
                $display("FAIL ready_no_valid cyc %0d: p %b/%b o %b/%b", cyc,
                         p_req_ready, p_req_valid, o_req_ready, o_req_valid);
            end
            checks++;
            if (p_resp_valid && o_resp_valid) begin
                errors++;
                $display("FAIL resp_excl cyc %0d: both resp_valid", cyc);
            end
            if (p_resp_valid || o_resp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp cyc %0d: p %b o %b, none pending",
                             cyc, p_resp_valid, o_resp_valid);
                end else begin
                    exp_t e;
                    logic [DW-1:0] gc, gs;
                    e  = sb.pop_front();
                    gc = e.id ? o_cos : p_cos;
                    gs = e.id ? o_sin : p_sin;
                    if (o_resp_valid !== e.id || gc !== e.c || gs !== e.s ||
                        cyc != e.at + LAT + 1) begin
                        errors++;
                        $display("FAIL resp cyc %0d: got id %b cos %0d sin %0d, need id %b cos %0d sin %0d cyc %0d",
                                 cyc, o_resp_valid, gc, gs, e.id, e.c, e.s, e.at + LAT + 1);
                    end
                end
            end
            if (p_req_ready || o_req_ready) begin
                exp_t e;
                logic [AW-1:0] na;
                na   = norm(o_req_ready ? o_req_angle : p_req_angle);
                e.id = o_req_ready;
                e.c  = cos_of(na);
                e.s  = sin_of(na);
                e.at = cyc;
                sb.push_back(e);
                n_acc++;
                checks++;
                if (rom_en !== 1'b1 || rom_addr !== na) begin
                    errors++;
                    $display("FAIL rom_strobe cyc %0d: en %b addr %0d, need 1 addr %0d",
                             cyc, rom_en, rom_addr, na);
                end
            end
            wait_p = (p_req_valid && !p_req_ready) ? wait_p + 1 : 0;
            wait_o = (o_req_valid && !o_req_ready) ? wait_o + 1 : 0;
            if (p_req_valid || o_req_valid) begin
                checks++;
                if (wait_p > 1 || wait_o > 1) begin
                    errors++;
                    $display("FAIL fairness cyc %0d: waits p %0d o %0d, max 1",
                             cyc, wait_p, wait_o);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        p_req_valid = 1'b1;
        o_req_valid = 1'b1;
        p_req_angle = 9'd10;
        o_req_angle = 9'd20;
        repeat (2) step();
        @(negedge clk);
        checks++;
        if ({p_req_ready, o_req_ready, rom_en, p_resp_valid, o_resp_valid, busy} !== 6'b0 ||
            rom_addr !== '0 || p_cos !== '0 || p_sin !== '0 || o_cos !== '0 || o_sin !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy %b%b en %b rv %b%b busy %b addr %0d, need all 0",
                     p_req_ready, o_req_ready, rom_en, p_resp_valid, o_resp_valid, busy, rom_addr);
        end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] ea;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ea = (i % 2 == 0) ? 9'd10 : 9'd20;
            checks++;
            if (p_req_ready !== (i % 2 == 0) || o_req_ready !== (i % 2 == 1) ||
                rom_addr !== ea) begin
                errors++;
                $display("FAIL rr_grant %0d: p %b o %b addr %0d, need p %b addr %0d",
                         i, p_req_ready, o_req_ready, rom_addr, i % 2 == 0, ea);
            end
            step();
        end
        p_req_valid = 1'b0;
        o_req_valid = 1'b0;
        repeat (6) step();
    endtask

    task automatic test_single();
        p_req_valid = 1'b1;
        p_req_angle = 9'd90;
        @(negedge clk);
        checks++;
        if (p_req_ready !== 1'b1 || rom_addr !== 9'd90) begin
            errors++;
            $display("FAIL single_accept: ready %b addr %0d, need 1 addr 90",
                     p_req_ready, rom_addr);
        end
        step();
        p_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (p_resp_valid !== 1'b1 || o_resp_valid !== 1'b0 ||
            p_cos !== '0 || p_sin !== DW'(1024)) begin
            errors++;
            $display("FAIL single_resp: pv %b ov %b cos %0d sin %0d, need 1 0 0 1024",
                     p_resp_valid, o_resp_valid, p_cos, p_sin);
        end
        repeat (3) step();
    endtask

    task automatic test_normalise();
        logic [AW-1:0] ang [3];
        logic [AW-1:0] exp_a [3];
        ang   = '{9'd359, 9'd360, 9'd400};
        exp_a = '{9'd359, 9'd0, 9'd40};
        o_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            o_req_angle = ang[i];
            @(negedge clk);
            checks++;
            if (o_req_ready !== 1'b1 || rom_addr !== exp_a[i]) begin
                errors++;
                $display("FAIL norm %0d: ready %b addr %0d, need 1 addr %0d",
                         ang[i], o_req_ready, rom_addr, exp_a[i]);
            end
            step();
        end
        o_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rom_en !== 1'b0 || rom_addr !== 9'd40) begin
            errors++;
            $display("FAIL addr_hold: en %b addr %0d, need 0 addr 40", rom_en, rom_addr);
        end
        repeat (5) step();
    endtask

    task automatic test_data_hold();
        p_req_valid = 1'b1;
        p_req_angle = 9'd0;
        step();
        p_req_valid = 1'b0;
        repeat (4) step();
        o_req_valid = 1'b1;
        o_req_angle = 9'd50;
        step();
        o_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (p_cos !== DW'(1024) || p_sin !== '0 || p_resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL data_hold %0d: pv %b cos %0d sin %0d, need 0 1024 0",
                         i, p_resp_valid, p_cos, p_sin);
            end
            step();
        end
        checks++;
        if (o_cos !== DW'(101) || o_sin !== DW'(155)) begin
            errors++;
            $display("FAIL opp_data: cos %0d sin %0d, need 101 155", o_cos, o_sin);
        end
    endtask

    task automatic test_reset_flush();
        p_req_valid = 1'b1;
        p_req_angle = 9'd45;
        @(negedge clk);
        checks++;
        if (p_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_accept: ready %b, need 1", p_req_ready);
        end
        step();
        p_req_valid = 1'b0;
        rst_n       = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({p_resp_valid, o_resp_valid, busy, rom_en} !== 4'b0 || rom_addr !== '0 ||
                p_cos !== '0 || p_sin !== '0 || o_cos !== '0 || o_sin !== '0) begin
                errors++;
                $display("FAIL flush %0d: rv %b%b busy %b en %b addr %0d pcos %0d psin %0d, need 0",
                         i, p_resp_valid, o_resp_valid, busy, rom_en, rom_addr, p_cos, p_sin);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic pg, og;
        int   start;
        start = n_acc;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            pg = p_req_ready;
            og = o_req_ready;
            step();
            if (!p_req_valid || pg) begin
                p_req_valid = ($urandom_range(0, 3) != 0);
                p_req_angle = AW'($urandom_range(0, 511));
            end
            if (!o_req_valid || og) begin
                o_req_valid = ($urandom_range(0, 3) != 0);
                o_req_angle = AW'($urandom_range(0, 511));
            end
        end
        p_req_valid = 1'b0;
        o_req_valid = 1'b0;
        repeat (6) step();
        checks++;
        if (sb.size() != 0 || n_acc - start < 5000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: pending %0d accepted %0d busy %b, need 0 >=5000 0",
                     sb.size(), n_acc - start, busy);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        p_req_valid = 1'b0;
        o_req_valid = 1'b0;
        p_req_angle = '0;
        o_req_angle = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_normalise();
        test_data_hold();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
